// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that turns one requester's 2-bit command into a single-cycle J/K drive.
// Optional macro JK_ARB_STATS_EN adds an 8-bit saturating count of applied toggle commands.
module jk_cmd_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] cmd,
    output logic [N_REQ-1:0]   gnt,
    output logic               j,
    output logic               k,
    output logic               busy,
    output logic               q_exp
`ifdef JK_ARB_STATS_EN
    ,
    output logic [7:0]         toggle_cnt
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   w_gnt_next;
    logic               r_j;
    logic               r_k;
    logic               w_j_next;
    logic               w_k_next;
    logic               r_q_exp;
    logic               w_q_next;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [1:0]         w_cmd_sel;

    // Scan from the pointer upward with wrap; the first pending requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!w_found && req[(int'(r_ptr) + off) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + off) % N_REQ);
            end
        end
    end

    always_comb begin
        if (int'(w_win) == N_REQ - 1) begin
            w_ptr_inc = '0;
        end else begin
            w_ptr_inc = w_win + 1'b1;
        end
        w_cmd_sel = cmd[2*int'(w_win) +: 2];
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_gnt_next   = '0;
        w_j_next     = 1'b0;
        w_k_next     = 1'b0;
        w_q_next     = r_q_exp;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_DRIVE;
                    w_ptr_next   = w_ptr_inc;
                    w_gnt_next   = N_REQ'(1) << w_win;
                    w_j_next     = w_cmd_sel[1];
                    w_k_next     = w_cmd_sel[0];
                end
            end
            S_DRIVE: begin
                // The latched J/K pair is the command itself, so apply JK semantics to the shadow.
                w_state_next = S_RECOVER;
                case ({r_j, r_k})
                    2'b01:   w_q_next = 1'b0;
                    2'b10:   w_q_next = 1'b1;
                    2'b11:   w_q_next = ~r_q_exp;
                    default: w_q_next = r_q_exp;
                endcase
            end
            S_RECOVER: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_q_exp <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_gnt   <= w_gnt_next;
            r_j     <= w_j_next;
            r_k     <= w_k_next;
            r_q_exp <= w_q_next;
        end
    end

`ifdef JK_ARB_STATS_EN
    logic [7:0] r_toggle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle_cnt <= 8'd0;
        end else if (r_state == S_DRIVE && r_j && r_k && r_toggle_cnt != 8'hFF) begin
            r_toggle_cnt <= r_toggle_cnt + 8'd1;
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`endif

    assign gnt   = r_gnt;
    assign j     = r_j;
    assign k     = r_k;
    assign q_exp = r_q_exp;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Directed bench for jk_cmd_arbiter (N_REQ=4): hand-computed grants, J/K drive and shadow Q.
module tb_jk_cmd_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] cmd;
    logic [3:0] gnt;
    logic       j;
    logic       k;
    logic       busy;
    logic       q_exp;
`ifdef JK_ARB_STATS_EN
    logic [7:0] toggle_cnt;
`endif

    int total = 0;
    int bad   = 0;

    jk_cmd_arbiter #(.N_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .cmd   (cmd),
        .gnt   (gnt),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .q_exp (q_exp)
`ifdef JK_ARB_STATS_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic e_j,
                           input logic e_k, input logic e_busy, input logic e_q);
        chk({tag, ".gnt"},  32'(gnt),   32'(e_gnt));
        chk({tag, ".j"},    32'(j),     32'(e_j));
        chk({tag, ".k"},    32'(k),     32'(e_k));
        chk({tag, ".busy"}, 32'(busy),  32'(e_busy));
        chk({tag, ".q"},    32'(q_exp), 32'(e_q));
    endtask

    initial begin
        logic exp_q;

        // Reset state
        rst_n = 1'b0;
        req   = 4'b0000;
        cmd   = 8'h00;
        #3;
        chk_out("rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_out("idle_noreq", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single set command from requester 0 (ptr -> 1)
        req = 4'b0001;
        cmd = 8'b00_00_00_10;
        tick();
        chk_out("set.drive", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("set.recov", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("set.idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Hold command from requester 2 still takes a full slot (ptr -> 3)
        req = 4'b0100;
        cmd = 8'b00_00_00_00;
        tick();
        chk_out("hold.drive", 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        chk_out("hold.recov", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("hold.idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Wrap-around from ptr=3, then req=1001 grants 3 then 0
        req = 4'b0001;
        cmd = 8'hFF;
        tick();
        chk_out("wrap.drive", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
        req = 4'b1001;
        tick();
        chk("wrap.q", 32'(q_exp), 32'd0);
        tick();
        tick();
        chk_out("rr3.drive", 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("rr3.q", 32'(q_exp), 32'd1);
        tick();
        tick();
        chk_out("rr0.drive", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        chk("rr0.q", 32'(q_exp), 32'd0);
        tick();

        // Reset asserted mid-DRIVE aborts the command immediately
        req = 4'b0001;
        cmd = 8'b00_00_00_10;
        tick();
        chk_out("abort.drive", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("abort.rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("abort.q", 32'(q_exp), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0010;
        cmd   = 8'b00_00_01_00;
        #1;
        chk_out("rel.nochg", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rel.drive", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("rel.recov", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Continuous all-toggle requests from a fresh reset: rotation 0,1,2,3,0
        rst_n = 1'b0;
        req   = 4'b1111;
        cmd   = 8'hFF;
        tick();
        rst_n = 1'b1;
        #1;
        chk("cont.nochg", 32'(gnt), 32'd0);
        exp_q = 1'b0;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("cont%0d.gnt", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            chk($sformatf("cont%0d.jk", g), 32'({j, k}), 32'd3);
            tick();
            exp_q = ~exp_q;
            chk($sformatf("cont%0d.q", g), 32'(q_exp), 32'(exp_q));
            tick();
            chk($sformatf("cont%0d.busy", g), 32'(busy), 32'd0);
        end
        chk("cont.final_q", 32'(q_exp), 32'd1);
`ifdef JK_ARB_STATS_EN
        chk("stat.five", 32'(toggle_cnt), 32'd5);
        req = 4'b0001;
        for (int g = 0; g < 300; g++) begin
            tick();
            tick();
            tick();
        end
        req = 4'b0000;
        tick();
        chk("stat.sat", 32'(toggle_cnt), 32'd255);
        rst_n = 1'b0;
        #1;
        chk("stat.rst", 32'(toggle_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
`endif
        req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, N_REQ, per-requester request level.
REQ-005 The block SHALL have port cmd, input, 2*N_REQ, per-requester command; requester i uses bits [2i+1:2i]; 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 The block SHALL have port gnt, output, N_REQ, one-hot registered grant pulse.
REQ-007 The block SHALL have port j, output, 1, registered J drive to the downstream JK flip-flop.
REQ-008 The block SHALL have port k, output, 1, registered K drive to the downstream JK flip-flop.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port q_exp, output, 1, shadow of the expected flip-flop Q after every applied command.

Function
REQ-011 The block SHALL implement FSM states IDLE, DRIVE and RECOVER; IDLE->DRIVE when any req bit is high, DRIVE->RECOVER unconditionally, RECOVER->IDLE unconditionally.
REQ-012 req and cmd SHALL be sampled only in IDLE; changes in DRIVE or RECOVER are ignored.
REQ-013 On the IDLE->DRIVE edge the block SHALL select winner w by round-robin starting at pointer ptr, then assert gnt[w] and set {j,k} = {cmd_w[1], cmd_w[0]}.
REQ-014 gnt SHALL be high for exactly the one DRIVE cycle; j/k SHALL be non-zero only in DRIVE.
REQ-015 On the DRIVE->RECOVER edge the block SHALL clear gnt, j and k, and update q_exp: 00 keep, 01 to 0, 10 to 1, 11 invert.
REQ-016 ptr SHALL become (w+1) mod N_REQ on the IDLE->DRIVE edge; ptr SHALL be unchanged when no request is pending.
REQ-017 A hold command (00) SHALL still be granted and consume a full 3-cycle slot with j=k=0.
REQ-018 Minimum spacing between grants SHALL be 3 cycles; with all requesters asserted continuously, grants SHALL rotate 0,1,..,N_REQ-1,0 with no requester granted twice before every other pending requester is granted once.
REQ-019 A requester SHALL deassert req in the cycle after seeing gnt; if it does not, it SHALL be treated as a new request at the next IDLE.
REQ-020 Wrap-around: with ptr=N_REQ-1 and only req[0] high, the winner SHALL be 0.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, gnt=0, j=0, k=0, busy=0, q_exp=0 and ptr=0, independent of clk.
REQ-022 Reset asserted during DRIVE SHALL abort the command with no q_exp update; the first grant after release SHALL follow the REQ-013 timing from IDLE.
REQ-023 Reset release SHALL be synchronous-safe: the first state transition SHALL occur no earlier than the first posedge after rst_n rises.

Configuration
REQ-024 When macro JK_ARB_STATS_EN is defined, the block SHALL add output toggle_cnt, 8 bits, counting applied toggle (11) commands, incrementing on the DRIVE->RECOVER edge, saturating at 255, and reset to 0 by rst_n.
REQ-025 When JK_ARB_STATS_EN is undefined, toggle_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Reset then req=0001, cmd0=10 -> gnt=0001 with j=1,k=0 for one cycle; q_exp=1 one cycle later; busy high for 2 cycles.
REQ-027 Continuous req=1111, all cmd=11 -> grants 0,1,2,3,0 every 3 cycles; q_exp toggles after each grant, ending at 1 after 5 grants.
REQ-028 ptr=3, req=0001 -> gnt=0001 (wrap-around); then req=1001 -> next grant to requester 3, then requester 0.
REQ-029 rst_n pulled low mid-DRIVE with cmd=10 -> j,k,gnt immediately 0, q_exp stays 0; after release req=0010, cmd1=01 -> normal grant.
REQ-030 cmd=00 from requester 2 alone -> gnt=0100 for one cycle, j=k=0 throughout, q_exp unchanged.
REQ-031 With JK_ARB_STATS_EN defined, 300 toggle grants -> toggle_cnt=255; a reset returns it to 0.
